// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// In-order scoreboard and write-port scheduler for the Issue stage.
// It tracks pending destination registers so that RAW and WAW hazards stall
// issue. It also reserves slots on the single register-file write port so that
// the AluMisc, Mem and Mult units never reach Writeback in the same cycle.
//
// Ports
//   clock, reset        : clock; synchronous active-low reset
//   id_iss_*            : instruction presented by Decode
//   wb_reg_en/addr      : register-file commit from Writeback
//   iss_stall           : hold Fetch, Decode and Issue
//   iss_*_oper          : per-unit fire strobe, one-hot or all zero
//   sb_pending          : registered pending-write bit per register (bit 0 = 0)
//   sb_wbres            : registered write-port reservation vector
//                         (bit k = a writeback is due k cycles from now)
//   sb_err              : sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int LAT_AM  = 3,
    parameter int LAT_MEM = 2,
    parameter int LAT_MUL = 4,
    parameter int DEPTH   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_iss_valid,
    input  logic [1:0]       id_iss_unit,
    input  logic [4:0]       id_iss_addra,
    input  logic [4:0]       id_iss_addrb,
    input  logic             id_iss_usea,
    input  logic             id_iss_useb,
    input  logic [4:0]       id_iss_regdest,
    input  logic             id_iss_writereg,
    input  logic             wb_reg_en,
    input  logic [4:0]       wb_reg_addr,
    output logic             iss_stall,
    output logic             iss_am_oper,
    output logic             iss_mem_oper,
    output logic             iss_mul_oper,
    output logic [31:0]      sb_pending,
    output logic [DEPTH-1:0] sb_wbres,
    output logic             sb_err
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        UNIT_AM  = 2'd0,
        UNIT_MEM = 2'd1,
        UNIT_MUL = 2'd2,
        UNIT_BAD = 2'd3
    } unit_e;

    unit_e            unit;
    logic             valid_ok;
    logic [IW-1:0]    lat;
    logic             raw;
    logic             waw;
    logic             wbc;
    logic             fire;
    logic             writes;
    logic [31:0]      set_vec;
    logic [31:0]      clr_vec;
    logic [31:0]      pending_n;
    logic [DEPTH-1:0] wbres_n;
    logic             err_n;

    assign unit = unit_e'(id_iss_unit);

    // Hazard detection, strobes and next-state, all from registered state only
    // (a writeback retiring this cycle is not bypassed).
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        lat      = IW'(LAT_AM);
        valid_ok = id_iss_valid && (unit != UNIT_BAD);

        case (unit)
            UNIT_MEM: lat = IW'(LAT_MEM);
            UNIT_MUL: lat = IW'(LAT_MUL);
            default:  lat = IW'(LAT_AM);
        endcase

        raw = (id_iss_usea && (id_iss_addra != 5'd0) && sb_pending[id_iss_addra]) ||
              (id_iss_useb && (id_iss_addrb != 5'd0) && sb_pending[id_iss_addrb]);
        waw = id_iss_writereg && (id_iss_regdest != 5'd0) && sb_pending[id_iss_regdest];
        // Write-port conflict: the slot this instruction would land in is taken.
        wbc = id_iss_writereg && sb_wbres[lat];

        // Stall is forced high during reset so nothing fires.
        iss_stall = !reset || (valid_ok && (raw || waw || wbc));
        fire      = valid_ok && !iss_stall;
        writes    = fire && id_iss_writereg;

        iss_am_oper  = fire && (unit == UNIT_AM);
        iss_mem_oper = fire && (unit == UNIT_MEM);
        iss_mul_oper = fire && (unit == UNIT_MUL);

        set_vec = (writes && (id_iss_regdest != 5'd0)) ? (32'd1 << id_iss_regdest) : 32'd0;
        clr_vec = (wb_reg_en && (wb_reg_addr != 5'd0)) ? (32'd1 << wb_reg_addr) : 32'd0;

        // Set wins over clear on the same register.
        pending_n    = (sb_pending & ~clr_vec) | set_vec;
        pending_n[0] = 1'b0;

        // A writer firing now with latency L lands in slot L-1 after the shift.
        wbres_n = sb_wbres >> 1;
        if (writes) begin
            wbres_n = wbres_n | (DEPTH'(1) << (lat - IW'(1)));
        end

        err_n = sb_err ||
                (wb_reg_en != sb_wbres[0]) ||
                (wb_reg_en && (wb_reg_addr != 5'd0) && !sb_pending[wb_reg_addr]) ||
                (|(set_vec & clr_vec));
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            sb_pending <= '0;
            sb_wbres   <= '0;
            sb_err     <= 1'b0;
        end else begin
            sb_pending <= pending_n;
            sb_wbres   <= wbres_n;
            sb_err     <= err_n;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//
// Directed bench for issue_scoreboard with default parameters
// (LAT_AM=3, LAT_MEM=2, LAT_MUL=4, DEPTH=8). A small execution-unit model
// watches the fire strobes and returns the matching writeback L cycles later,
// as the real pipeline would; expected values are hand-computed per cycle.
// Inputs change at posedge+2, outputs are checked at posedge+3, the unit
// model drives writeback at negedge.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

    localparam int DEPTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             id_iss_valid;
    logic [1:0]       id_iss_unit;
    logic [4:0]       id_iss_addra;
    logic [4:0]       id_iss_addrb;
    logic             id_iss_usea;
    logic             id_iss_useb;
    logic [4:0]       id_iss_regdest;
    logic             id_iss_writereg;
    logic             wb_reg_en = 1'b0;
    logic [4:0]       wb_reg_addr = 5'd0;
    logic             iss_stall;
    logic             iss_am_oper;
    logic             iss_mem_oper;
    logic             iss_mul_oper;
    logic [31:0]      sb_pending;
    logic [DEPTH-1:0] sb_wbres;
    logic             sb_err;

    // Injected writeback, for protocol-error stimulus.
    logic             inj_en;
    logic [4:0]       inj_addr;

    int n_tests = 0;
    int n_fail  = 0;

    issue_scoreboard #(
        .LAT_AM (3),
        .LAT_MEM(2),
        .LAT_MUL(4),
        .DEPTH  (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .id_iss_valid   (id_iss_valid),
        .id_iss_unit    (id_iss_unit),
        .id_iss_addra   (id_iss_addra),
        .id_iss_addrb   (id_iss_addrb),
        .id_iss_usea    (id_iss_usea),
        .id_iss_useb    (id_iss_useb),
        .id_iss_regdest (id_iss_regdest),
        .id_iss_writereg(id_iss_writereg),
        .wb_reg_en      (wb_reg_en),
        .wb_reg_addr    (wb_reg_addr),
        .iss_stall      (iss_stall),
        .iss_am_oper    (iss_am_oper),
        .iss_mem_oper   (iss_mem_oper),
        .iss_mul_oper   (iss_mul_oper),
        .sb_pending     (sb_pending),
        .sb_wbres       (sb_wbres),
        .sb_err         (sb_err)
    );

    always #5 clock = ~clock;

    // Execution-unit model: line[k] holds the writeback due k cycles after the
    // current one. Reset flushes everything in flight.
    logic       line_en   [0:15];
    logic [4:0] line_addr [0:15];

    initial begin
        for (int i = 0; i < 16; i++) begin
            line_en[i]   = 1'b0;
            line_addr[i] = 5'd0;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                line_en[i]   = 1'b0;
                line_addr[i] = 5'd0;
            end
            wb_reg_en   = 1'b0;
            wb_reg_addr = 5'd0;
        end else begin
            wb_reg_en   = line_en[0] | inj_en;
            wb_reg_addr = inj_en ? inj_addr : line_addr[0];
            for (int i = 0; i < 15; i++) begin
                line_en[i]   = line_en[i+1];
                line_addr[i] = line_addr[i+1];
            end
            line_en[15]   = 1'b0;
            line_addr[15] = 5'd0;
            if (id_iss_writereg && (iss_am_oper || iss_mem_oper || iss_mul_oper)) begin
                int lat;
                lat = iss_am_oper ? 3 : (iss_mem_oper ? 2 : 4);
                line_en[lat-1]   = 1'b1;
                line_addr[lat-1] = id_iss_regdest;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic [1:0] unit, input logic [4:0] ra, input logic ua,
                         input logic [4:0] rb, input logic ub,
                         input logic [4:0] rd, input logic wr);
        id_iss_valid    = 1'b1;
        id_iss_unit     = unit;
        id_iss_addra    = ra;
        id_iss_usea     = ua;
        id_iss_addrb    = rb;
        id_iss_useb     = ub;
        id_iss_regdest  = rd;
        id_iss_writereg = wr;
    endtask

    task automatic idle();
        id_iss_valid    = 1'b0;
        id_iss_unit     = 2'd0;
        id_iss_addra    = 5'd0;
        id_iss_usea     = 1'b0;
        id_iss_addrb    = 5'd0;
        id_iss_useb     = 1'b0;
        id_iss_regdest  = 5'd0;
        id_iss_writereg = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            next();
            idle();
        end
    endtask

    function automatic logic [2:0] opers();
        return {iss_am_oper, iss_mem_oper, iss_mul_oper};
    endfunction

    initial begin
        reset    = 1'b0;
        inj_en   = 1'b0;
        inj_addr = 5'd0;
        idle();

        // Reset: stall forced, no strobes, state cleared.
        next();
        drive(2'd0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1);
        #1;
        check("rst_stall", iss_stall, 1);
        check("rst_opers", opers(), 3'b000);
        check("rst_pending", sb_pending, 0);
        check("rst_wbres", sb_wbres, 0);
        check("rst_err", sb_err, 0);
        next();
        reset = 1'b1;
        idle();
        #1;
        check("idle_stall", iss_stall, 0);

        // Unit 3 is treated as not valid: no stall, no strobe, no pending.
        next();
        drive(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        check("bad_unit_stall", iss_stall, 0);
        check("bad_unit_opers", opers(), 3'b000);
        next();
        idle();
        #1;
        check("bad_unit_pending", sb_pending, 0);
        idle_cycles(2);

        // RAW: Mult writes r5 at c0, AluMisc reads r5 from c1.
        next();
        drive(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        check("raw_mul_fire", opers(), 3'b001);
        next();
        drive(2'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("raw_pending_c1", sb_pending, 32'h0000_0020);
        check("raw_stall_c1", iss_stall, 1);
        for (int c = 2; c <= 4; c++) begin
            next();
            #1;
            check($sformatf("raw_stall_c%0d", c), iss_stall, 1);
            check($sformatf("raw_opers_c%0d", c), opers(), 3'b000);
        end
        next();
        #1;
        check("raw_stall_c5", iss_stall, 0);
        check("raw_am_fire_c5", opers(), 3'b100);
        check("raw_pending_c5", sb_pending, 0);
        idle_cycles(6);

        // Write-port conflict: Mult r3 at c0, AluMisc r4 at c1 (both due c4).
        next();
        drive(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        #1;
        check("wbc_mul_fire", opers(), 3'b001);
        next();
        drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        #1;
        check("wbc_stall_c1", iss_stall, 1);
        check("wbc_opers_c1", opers(), 3'b000);
        next();
        #1;
        check("wbc_stall_c2", iss_stall, 0);
        check("wbc_am_fire_c2", opers(), 3'b100);
        next();
        idle();
        #1;
        check("wbc_wbres_c3", sb_wbres, 8'b0000_0110);
        check("wbc_pending_c3", sb_pending, 32'h0000_0018);
        idle_cycles(6);
        check("wbc_pending_end", sb_pending, 0);
        check("wbc_err_end", sb_err, 0);

        // WAW: AluMisc r7 at c0, Mem r7 waits for the r7 commit at c3.
        next();
        drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        #1;
        check("waw_am_fire", opers(), 3'b100);
        next();
        drive(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        #1;
        check("waw_stall_c1", iss_stall, 1);
        for (int c = 2; c <= 3; c++) begin
            next();
            #1;
            check($sformatf("waw_stall_c%0d", c), iss_stall, 1);
            check($sformatf("waw_pending_c%0d", c), sb_pending, 32'h0000_0080);
        end
        next();
        #1;
        check("waw_stall_c4", iss_stall, 0);
        check("waw_mem_fire_c4", opers(), 3'b010);
        idle_cycles(6);
        check("waw_err_end", sb_err, 0);
        check("waw_pending_end", sb_pending, 0);

        // Register 0: no hazard, never pending, slot still reserved.
        next();
        drive(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        #1;
        check("r0_mul_fire", opers(), 3'b001);
        next();
        drive(2'd1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        check("r0_stall", iss_stall, 0);
        check("r0_mem_fire", opers(), 3'b010);
        check("r0_pending_c1", sb_pending, 0);
        next();
        idle();
        #1;
        check("r0_wbres_c2", sb_wbres, 8'b0000_0110);
        check("r0_pending_c2", sb_pending, 0);
        idle_cycles(6);
        check("r0_err_end", sb_err, 0);

        // Back-to-back independent AluMisc ops fire on consecutive cycles.
        next();
        drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
        #1;
        check("b2b_fire_c0", opers(), 3'b100);
        next();
        drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
        #1;
        check("b2b_fire_c1", opers(), 3'b100);
        next();
        idle();
        #1;
        check("b2b_pending_c2", sb_pending, 32'h0000_0006);
        check("b2b_wbres_c2", sb_wbres, 8'b0000_0110);
        idle_cycles(6);
        check("b2b_err_end", sb_err, 0);

        // Reset while a Mult write of r10 is in flight.
        next();
        drive(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
        #1;
        check("rif_mul_fire", opers(), 3'b001);
        next();
        idle();
        #1;
        check("rif_pending_c1", sb_pending, 32'h0000_0400);
        next();
        reset = 1'b0;
        drive(2'd0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
        #1;
        check("rif_stall_c2", iss_stall, 1);
        check("rif_opers_c2", opers(), 3'b000);
        next();
        reset = 1'b1;
        #1;
        check("rif_pending_c3", sb_pending, 0);
        check("rif_wbres_c3", sb_wbres, 0);
        check("rif_stall_c3", iss_stall, 0);
        check("rif_am_fire_c3", opers(), 3'b100);
        idle_cycles(6);
        check("rif_err_end", sb_err, 0);
        check("rif_pending_end", sb_pending, 0);

        // Unexpected writeback to r9 with no reservation: sticky error.
        next();
        idle();
        inj_en   = 1'b1;
        inj_addr = 5'd9;
        #1;
        check("err_before", sb_err, 0);
        check("err_wbres_empty", sb_wbres, 0);
        next();
        inj_en = 1'b0;
        #1;
        check("err_set", sb_err, 1);
        for (int c = 0; c < 3; c++) begin
            next();
            #1;
            check($sformatf("err_held_%0d", c), sb_err, 1);
        end
        next();
        reset = 1'b0;
        next();
        reset = 1'b1;
        #1;
        check("err_cleared", sb_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
